dmac_channel_dpath: RTL and testbench

Per-channel datapath of the AHB DMA controller. It sits directly under the channel controller and consumes that controller's select/enable strobes. It holds the source and destination address counters, the remaining-transfer-size and burst-length registers, the beat counter and the channel data FIFO. It returns the `bsz`, `tslb`, `tsz`, `fifo_full` and `fifo_empty` status the controller sequences on, and drives the AHB master address and write data.

---
 rtl/dmac_pkg.sv | 35 +++
 rtl/dmac_fifo.sv | 52 +++++
 rtl/dmac_channel_dpath.sv | 133 +++++++++++++
 tb/tb_dmac_channel_dpath.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared AHB encodings and default widths for the DMA controller.
// The optional DMAC_FIXED_ADDR_EN build macro is consumed by dmac_channel_dpath.
package dmac_pkg;

    localparam int DMAC_ADDR_W = 32;
    localparam int DMAC_DATA_W = 32;
    localparam int DMAC_TS_W   = 16;
    localparam int DMAC_BS_W   = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE    = 2'b00,
        HTRANS_BUSY    = 2'b01,
        HTRANS_NON_SEQ = 2'b10,
        HTRANS_SEQ     = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_4WORD = 3'b100,
        HSIZE_8WORD = 3'b101,
        HSIZE_512   = 3'b110,
        HSIZE_1024  = 3'b111
    } hsize_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

endpackage

// File: rtl/dmac_fifo.sv
// Show-ahead channel data FIFO with extra-bit pointers and a sticky overflow flag.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module dmac_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic              ovf_reg;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign ovf     = ovf_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (wr_en && !do_push) ovf_reg <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dmac_channel_dpath.sv
// Per-channel DMA datapath: address counters, size/burst/beat counters, status and FIFO.
// Build macro DMAC_FIXED_ADDR_EN adds cfg_src_fixed/cfg_dst_fixed to hold addresses on steps.
module dmac_channel_dpath
    import dmac_pkg::*;
#(
    parameter int ADDR_W     = DMAC_ADDR_W,
    parameter int DATA_W     = DMAC_DATA_W,
    parameter int TS_W       = DMAC_TS_W,
    parameter int BS_W       = DMAC_BS_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [TS_W-1:0]   cfg_trans_size,
    input  logic [BS_W-1:0]   cfg_burst_size,
    input  logic [2:0]        cfg_hsize,
`ifdef DMAC_FIXED_ADDR_EN
    input  logic              cfg_src_fixed,
    input  logic              cfg_dst_fixed,
`endif
    input  logic              b_sel,
    input  logic              d_sel,
    input  logic              t_sel,
    input  logic              s_sel,
    input  logic              h_sel,
    input  logic              d_en,
    input  logic              s_en,
    input  logic              ts_en,
    input  logic              burst_en,
    input  logic              count_en,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] HRData,
    output logic [ADDR_W-1:0] HAddr,
    output logic [DATA_W-1:0] HWData,
    output logic [2:0]        HSize,
    output logic              bsz,
    output logic              tslb,
    output logic              tsz,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_ovf
);

    logic [ADDR_W-1:0] src_addr_reg, src_addr_next;
    logic [ADDR_W-1:0] dst_addr_reg, dst_addr_next;
    logic [TS_W-1:0]   ts_rem_reg, ts_rem_next;
    logic [BS_W-1:0]   burst_len_reg, burst_len_next;
    logic [BS_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] src_step;
    logic [ADDR_W-1:0] dst_step;
    logic [TS_W-1:0]   ts_next;
    logic [TS_W-1:0]   burst_cand;
    logic [BS_W-1:0]   burst_load;

    assign inc = ADDR_W'(1) << cfg_hsize;

`ifdef DMAC_FIXED_ADDR_EN
    assign src_step = cfg_src_fixed ? '0 : inc;
    assign dst_step = cfg_dst_fixed ? '0 : inc;
`else
    assign src_step = inc;
    assign dst_step = inc;
`endif

    // Remaining size after the current burst, saturating at zero.
    assign ts_next = (ts_rem_reg > TS_W'(burst_len_reg)) ?
                     (ts_rem_reg - TS_W'(burst_len_reg)) : '0;

    assign burst_cand = b_sel ? ts_next : (t_sel ? cfg_trans_size : ts_rem_reg);
    assign burst_load = (burst_cand < TS_W'(cfg_burst_size)) ?
                        burst_cand[BS_W-1:0] : cfg_burst_size;

    always_comb begin
        src_addr_next  = src_addr_reg;
        dst_addr_next  = dst_addr_reg;
        ts_rem_next    = ts_rem_reg;
        burst_len_next = burst_len_reg;
        beat_cnt_next  = beat_cnt_reg;

        if (s_en)     src_addr_next  = s_sel ? cfg_src_addr : (src_addr_reg + src_step);
        if (d_en)     dst_addr_next  = d_sel ? cfg_dst_addr : (dst_addr_reg + dst_step);
        if (ts_en)    ts_rem_next    = t_sel ? cfg_trans_size : ts_next;
        if (burst_en) burst_len_next = burst_load;

        if (ts_en && t_sel)
            beat_cnt_next = '0;
        else if (count_en)
            beat_cnt_next = bsz ? '0 : (beat_cnt_reg + BS_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr_reg  <= '0;
            dst_addr_reg  <= '0;
            ts_rem_reg    <= '0;
            burst_len_reg <= '0;
            beat_cnt_reg  <= '0;
        end else begin
            src_addr_reg  <= src_addr_next;
            dst_addr_reg  <= dst_addr_next;
            ts_rem_reg    <= ts_rem_next;
            burst_len_reg <= burst_len_next;
            beat_cnt_reg  <= beat_cnt_next;
        end
    end

    assign bsz   = (beat_cnt_reg == burst_len_reg);
    assign tsz   = (ts_rem_reg == '0);
    assign tslb  = (ts_next < TS_W'(cfg_burst_size));
    assign HAddr = h_sel ? dst_addr_reg : src_addr_reg;
    assign HSize = cfg_hsize;

    dmac_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_data (HRData),
        .rd_data (HWData),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovf     (fifo_ovf)
    );

endmodule

// File: tb/tb_dmac_channel_dpath.sv
// Scoreboard bench for dmac_channel_dpath: directed scenarios then randomized strobes,
// checked against a queue-based reference model of the channel datapath.
module tb_dmac_channel_dpath;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_src_addr, cfg_dst_addr;
    logic [15:0] cfg_trans_size;
    logic [7:0]  cfg_burst_size;
    logic [2:0]  cfg_hsize;
`ifdef DMAC_FIXED_ADDR_EN
    logic        cfg_src_fixed, cfg_dst_fixed;
`endif
    logic        b_sel, d_sel, t_sel, s_sel, h_sel;
    logic        d_en, s_en, ts_en, burst_en, count_en, rd_en, wr_en;
    logic [31:0] HRData;
    logic [31:0] HAddr, HWData;
    logic [2:0]  HSize;
    logic        bsz, tslb, tsz, fifo_full, fifo_empty, fifo_ovf;

    always #5 clk = ~clk;

    dmac_channel_dpath dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_src_addr   (cfg_src_addr),
        .cfg_dst_addr   (cfg_dst_addr),
        .cfg_trans_size (cfg_trans_size),
        .cfg_burst_size (cfg_burst_size),
        .cfg_hsize      (cfg_hsize),
`ifdef DMAC_FIXED_ADDR_EN
        .cfg_src_fixed  (cfg_src_fixed),
        .cfg_dst_fixed  (cfg_dst_fixed),
`endif
        .b_sel          (b_sel),
        .d_sel          (d_sel),
        .t_sel          (t_sel),
        .s_sel          (s_sel),
        .h_sel          (h_sel),
        .d_en           (d_en),
        .s_en           (s_en),
        .ts_en          (ts_en),
        .burst_en       (burst_en),
        .count_en       (count_en),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .HRData         (HRData),
        .HAddr          (HAddr),
        .HWData         (HWData),
        .HSize          (HSize),
        .bsz            (bsz),
        .tslb           (tslb),
        .tsz            (tsz),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_ovf       (fifo_ovf)
    );

    typedef struct {
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [2:0]  hsize;
        logic        bsz, tslb, tsz, full, empty, ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: plain integers and a queue standing in for the FIFO.
    logic [31:0] m_src, m_dst;
    int          m_ts, m_bl, m_bc;
    logic [31:0] m_fifo[$];
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_ts = 0; m_bl = 0; m_bc = 0; m_ovf = 0;
        m_fifo.delete();
    endtask

    function automatic int remaining_after_burst(input int ts, input int bl);
        return (ts > bl) ? ts - bl : 0;
    endfunction

    task automatic model_step();
        int   tn, cand, bs, old_ts, old_bl, old_bc;
        logic sfix, dfix, popped;
        exp_t e;
        sfix = 1'b0; dfix = 1'b0;
`ifdef DMAC_FIXED_ADDR_EN
        sfix = cfg_src_fixed; dfix = cfg_dst_fixed;
`endif
        bs = int'(cfg_burst_size);
        if (rst) begin
            model_reset();
        end else begin
            old_ts = m_ts; old_bl = m_bl; old_bc = m_bc;
            tn = remaining_after_burst(old_ts, old_bl);
            if (s_en) m_src = s_sel ? cfg_src_addr : (sfix ? m_src : m_src + (32'd1 << cfg_hsize));
            if (d_en) m_dst = d_sel ? cfg_dst_addr : (dfix ? m_dst : m_dst + (32'd1 << cfg_hsize));
            if (ts_en) m_ts = t_sel ? int'(cfg_trans_size) : tn;
            if (burst_en) begin
                cand = b_sel ? tn : (t_sel ? int'(cfg_trans_size) : old_ts);
                m_bl = (cand < bs) ? cand : bs;
            end
            if (ts_en && t_sel) m_bc = 0;
            else if (count_en) m_bc = (old_bc == old_bl) ? 0 : (old_bc + 1) % 256;
            popped = rd_en && (m_fifo.size() > 0);
            if (popped) void'(m_fifo.pop_front());
            if (wr_en) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(HRData);
                else m_ovf = 1'b1;
            end
        end
        e.haddr  = h_sel ? m_dst : m_src;
        e.hwdata = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
        e.hsize  = cfg_hsize;
        e.bsz    = (m_bc == m_bl);
        e.tsz    = (m_ts == 0);
        e.tslb   = (remaining_after_burst(m_ts, m_bl) < bs);
        e.full   = (m_fifo.size() == DEPTH);
        e.empty  = (m_fifo.size() == 0);
        e.ovf    = m_ovf;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge with inputs settled; returns at the next negedge.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        b_sel = 0; d_sel = 0; t_sel = 0; s_sel = 0;
        d_en = 0; s_en = 0; ts_en = 0; burst_en = 0; count_en = 0;
        rd_en = 0; wr_en = 0; rst = 0;
`ifdef DMAC_FIXED_ADDR_EN
        cfg_src_fixed = 0; cfg_dst_fixed = 0;
`endif
    endtask

    task automatic rand_step(input int wr_pct, input int rd_pct);
        rst = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 19) == 0) begin
            cfg_src_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            cfg_dst_addr   = $urandom;
            cfg_trans_size = 16'($urandom_range(0, 40));
            cfg_burst_size = 8'($urandom_range(1, 8));
            cfg_hsize      = 3'($urandom_range(0, 3));
        end
`ifdef DMAC_FIXED_ADDR_EN
        cfg_src_fixed = 1'($urandom); cfg_dst_fixed = 1'($urandom);
`endif
        b_sel = 1'($urandom); d_sel = ($urandom_range(0, 7) == 0);
        t_sel = ($urandom_range(0, 7) == 0); s_sel = ($urandom_range(0, 7) == 0);
        h_sel = 1'($urandom);
        d_en = 1'($urandom); s_en = 1'($urandom); ts_en = ($urandom_range(0, 3) == 0);
        burst_en = ($urandom_range(0, 3) == 0); count_en = 1'($urandom);
        wr_en = ($urandom_range(0, 99) < wr_pct);
        rd_en = ($urandom_range(0, 99) < rd_pct);
        HRData = $urandom;
        cycle();
    endtask

    // Monitor: every cycle the DUT presents status; pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("HAddr",      HAddr,      e.haddr);
                chk("HWData",     HWData,     e.hwdata);
                chk("HSize",      {29'd0, HSize}, {29'd0, e.hsize});
                chk("bsz",        {31'd0, bsz},        {31'd0, e.bsz});
                chk("tslb",       {31'd0, tslb},       {31'd0, e.tslb});
                chk("tsz",        {31'd0, tsz},        {31'd0, e.tsz});
                chk("fifo_full",  {31'd0, fifo_full},  {31'd0, e.full});
                chk("fifo_empty", {31'd0, fifo_empty}, {31'd0, e.empty});
                chk("fifo_ovf",   {31'd0, fifo_ovf},   {31'd0, e.ovf});
            end
        end
    end

    initial begin
        cfg_src_addr = 0; cfg_dst_addr = 0; cfg_trans_size = 0;
        cfg_burst_size = 4; cfg_hsize = 2; h_sel = 0; HRData = 0;
        idle();
        rst = 1;
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        idle();

        // Program a 10-beat transfer in bursts of 4 words.
        cfg_src_addr = 32'h1000; cfg_dst_addr = 32'h2000;
        cfg_trans_size = 16'd10; cfg_burst_size = 8'd4; cfg_hsize = 3'd2;
        s_en = 1; d_en = 1; ts_en = 1; burst_en = 1;
        s_sel = 1; d_sel = 1; t_sel = 1; b_sel = 0;
        cycle();
        idle(); h_sel = 1; cycle();
        h_sel = 0;
        for (int i = 0; i < 4; i++) begin
            count_en = 1; s_en = 1; cycle();
        end
        idle(); count_en = 1; cycle();
        idle(); ts_en = 1; cycle();
        ts_en = 1; burst_en = 1; b_sel = 1; cycle();
        idle(); ts_en = 1; cycle();
        idle(); cycle();

        // Fill past full, then drain past empty.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; HRData = 32'hA0 + i; cycle();
        end
        idle();
        for (int i = 0; i < 17; i++) begin
            rd_en = 1; cycle();
        end
        idle(); cycle();

        // Reset in the middle of a burst with data in the FIFO.
        s_en = 1; d_en = 1; ts_en = 1; burst_en = 1; s_sel = 1; d_sel = 1; t_sel = 1;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            count_en = 1; s_en = 1; wr_en = 1; HRData = $urandom; cycle();
        end
        idle(); rst = 1; cycle();
        idle(); cycle();

        // Fixed source against incrementing destination.
        s_en = 1; d_en = 1; s_sel = 1; d_sel = 1; cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
`ifdef DMAC_FIXED_ADDR_EN
            cfg_src_fixed = 1;
`endif
            s_en = 1; d_en = 1; h_sel = i[0]; cycle();
        end
        idle(); cycle();

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 400; i++) begin
                case (p % 3)
                    0: rand_step(80, 20);
                    1: rand_step(20, 80);
                    default: rand_step(50, 50);
                endcase
            end
        end
        idle(); cycle();

        @(posedge clk); #2;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
